// File: rtl/tx_pkg.sv
// Shared types and constants for the SPI nibble transmit stage.
// Provides the FSM state enum, sizing constants and the nibble selector.
package tx_pkg;

   typedef enum logic [1:0] {IDLE, SEND, DONE} tx_state_t;

   localparam int NIBBLES = 3;
   localparam int DATA_W  = 10;
   localparam int SYNC_FF = 2;

   // Nibble 0 carries the two top result bits, zero-extended.
   function automatic logic [3:0] nibble(input logic [DATA_W-1:0] d,
                                         input logic [1:0] idx);
      logic [3:0] n;
      case (idx)
         2'd0:    n = {2'b00, d[9:8]};
         2'd1:    n = d[7:4];
         default: n = d[3:0];
      endcase
      return n;
   endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchroniser plus rising-edge detector for an asynchronous input.
// Ports: clk, rst_n (sync, active-high), async_in -> level, rise (1-cycle pulse).
module spi_edge_sync #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic level,
   output logic rise
);

   logic [DEPTH-1:0] sync_q;
   logic             prev_q;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[DEPTH-2:0], async_in};
         prev_q <= sync_q[DEPTH-1];
      end
   end

   assign level = sync_q[DEPTH-1];
   assign rise  = sync_q[DEPTH-1] & ~prev_q;

endmodule

// File: rtl/tx_4b.sv
// SPI transmit stage: takes a 10-bit result + carry by valid/ready and
// shifts it out as three MSB-first nibbles on miso, one per SPI clock rise.
// Ports: clk, rst_n (sync, active-high), spi_clk, spi_r, res_data, carry_in,
// res_valid, res_ready, miso, carry_out, tx_done.
module tx_4b
   import tx_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_clk,
   input  logic              spi_r,
   input  logic [DATA_W-1:0] res_data,
   input  logic              carry_in,
   input  logic              res_valid,
   output logic              res_ready,
   output logic [3:0]        miso,
   output logic              carry_out,
   output logic              tx_done
);

   localparam logic [1:0] LAST = 2'(NIBBLES - 1);

   tx_state_t         state;
   logic [1:0]        nib_cnt;
   logic [DATA_W-1:0] cap_q;

   logic clk_level, clk_rise;
   logic r_level, r_rise;
   logic spare_unused;

   spi_edge_sync #(.DEPTH(SYNC_FF)) u_clk_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (spi_clk),
      .level    (clk_level),
      .rise     (clk_rise)
   );

   spi_edge_sync #(.DEPTH(SYNC_FF)) u_r_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (spi_r),
      .level    (r_level),
      .rise     (r_rise)
   );

   assign spare_unused = clk_level ^ r_rise;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state     <= IDLE;
         nib_cnt   <= 2'd0;
         cap_q     <= '0;
         miso      <= 4'd0;
         carry_out <= 1'b0;
         res_ready <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (res_valid && res_ready) begin
                  cap_q     <= res_data;
                  nib_cnt   <= 2'd0;
                  miso      <= nibble(res_data, 2'd0);
                  carry_out <= carry_in;
                  res_ready <= 1'b0;
                  state     <= SEND;
               end else begin
                  miso      <= 4'd0;
                  carry_out <= 1'b0;
                  res_ready <= 1'b1;
               end
            end
            SEND: begin
               // A low read enable freezes the transfer.
               if (clk_rise && r_level) begin
                  if (nib_cnt < LAST) begin
                     nib_cnt <= nib_cnt + 2'd1;
                     miso    <= nibble(cap_q, nib_cnt + 2'd1);
                  end else begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               // Ready rises here so the first IDLE cycle can handshake.
               miso      <= 4'd0;
               carry_out <= 1'b0;
               res_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign tx_done = (state == DONE);

endmodule

// File: tb/tb_tx_4b.sv
// Directed self-checking bench for tx_4b.
// Drives handshakes and SPI clock pulses, checks miso/carry/done/ready.
module tb_tx_4b;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       spi_clk = 1'b0;
   logic       spi_r = 1'b0;
   logic [9:0] res_data = '0;
   logic       carry_in = 1'b0;
   logic       res_valid = 1'b0;
   logic       res_ready;
   logic [3:0] miso;
   logic       carry_out;
   logic       tx_done;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   tx_4b dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .spi_clk   (spi_clk),
      .spi_r     (spi_r),
      .res_data  (res_data),
      .carry_in  (carry_in),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .miso      (miso),
      .carry_out (carry_out),
      .tx_done   (tx_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (rst_n == 1'b0 && tx_done === 1'b1) done_cnt++;

   task automatic spi_pulse();
      spi_clk = 1'b1;
      #50;
      spi_clk = 1'b0;
      #50;
   endtask

   task automatic send_word(input logic [9:0] d, input logic c);
      bit ok = 0;
      @(negedge clk);
      res_data  = d;
      carry_in  = c;
      res_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (res_ready === 1'b1) begin
            @(posedge clk);
            #1 res_valid = 1'b0;
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!ok) begin
         errors++;
         res_valid = 1'b0;
         $display("FAIL handshake_timeout got=no_ready exp=ready");
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (miso !== 4'h0) begin
         errors++;
         $display("FAIL rst_miso got=%h exp=0", miso);
      end
      checks++;
      if (carry_out !== 1'b0 || tx_done !== 1'b0) begin
         errors++;
         $display("FAIL rst_cd got=%b%b exp=00", carry_out, tx_done);
      end
      checks++;
      if (res_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_ready got=%b exp=0", res_ready);
      end
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (res_ready !== 1'b1) begin
         errors++;
         $display("FAIL rel_ready got=%b exp=1", res_ready);
      end
   endtask

   task automatic test_basic();
      logic [3:0] exp [3];
      int d0;
      exp = '{4'h2, 4'hA, 4'h5};
      spi_r = 1'b1;
      #50;
      d0 = done_cnt;
      send_word(10'h2A5, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (miso !== exp[i] || carry_out !== 1'b1) begin
            errors++;
            $display("FAIL basic_nib%0d got=%h/%b exp=%h/1",
                     i, miso, carry_out, exp[i]);
         end
         checks++;
         if (done_cnt != d0) begin
            errors++;
            $display("FAIL basic_early_done%0d got=%0d exp=%0d",
                     i, done_cnt, d0);
         end
         spi_pulse();
      end
      checks++;
      if (done_cnt != d0 + 1) begin
         errors++;
         $display("FAIL basic_done got=%0d exp=%0d", done_cnt, d0 + 1);
      end
      @(negedge clk);
      checks++;
      if (res_ready !== 1'b1 || miso !== 4'h0) begin
         errors++;
         $display("FAIL basic_idle got=%b/%h exp=1/0", res_ready, miso);
      end
   endtask

   task automatic test_pause();
      int d0;
      spi_r = 1'b1;
      d0 = done_cnt;
      send_word(10'h3FF, 1'b0);
      @(negedge clk);
      checks++;
      if (miso !== 4'h3) begin
         errors++;
         $display("FAIL pause_n0 got=%h exp=3", miso);
      end
      spi_pulse();
      spi_r = 1'b0;
      #50;
      repeat (2) spi_pulse();
      @(negedge clk);
      checks++;
      if (miso !== 4'hF || done_cnt != d0) begin
         errors++;
         $display("FAIL pause_hold got=%h/%0d exp=f/%0d",
                  miso, done_cnt, d0);
      end
      spi_r = 1'b1;
      #50;
      spi_pulse();
      checks++;
      if (miso !== 4'hF || done_cnt != d0) begin
         errors++;
         $display("FAIL pause_resume1 got=%h/%0d exp=f/%0d",
                  miso, done_cnt, d0);
      end
      spi_pulse();
      checks++;
      if (done_cnt != d0 + 1) begin
         errors++;
         $display("FAIL pause_done got=%0d exp=%0d", done_cnt, d0 + 1);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp2 [3];
      int d0;
      exp2 = '{4'h1, 4'hE, 4'h7};
      spi_r = 1'b1;
      d0 = done_cnt;
      send_word(10'h0C3, 1'b0);
      @(negedge clk);
      res_data  = 10'h1E7;
      carry_in  = 1'b1;
      res_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (res_ready !== 1'b0 || miso !== 4'h0 || carry_out !== 1'b0) begin
         errors++;
         $display("FAIL bp_hold0 got=%b/%h/%b exp=0/0/0",
                  res_ready, miso, carry_out);
      end
      spi_pulse();
      checks++;
      if (miso !== 4'hC || res_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_n1 got=%h/%b exp=c/0", miso, res_ready);
      end
      spi_pulse();
      checks++;
      if (miso !== 4'h3 || carry_out !== 1'b0) begin
         errors++;
         $display("FAIL bp_n2 got=%h/%b exp=3/0", miso, carry_out);
      end
      spi_pulse();
      @(negedge clk);
      res_valid = 1'b0;
      checks++;
      if (done_cnt != d0 + 1) begin
         errors++;
         $display("FAIL bp_done1 got=%0d exp=%0d", done_cnt, d0 + 1);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (miso !== exp2[i] || carry_out !== 1'b1) begin
            errors++;
            $display("FAIL bp_new_nib%0d got=%h/%b exp=%h/1",
                     i, miso, carry_out, exp2[i]);
         end
         spi_pulse();
      end
      checks++;
      if (done_cnt != d0 + 2) begin
         errors++;
         $display("FAIL bp_done2 got=%0d exp=%0d", done_cnt, d0 + 2);
      end
   endtask

   task automatic test_mid_reset();
      int d0;
      spi_r = 1'b1;
      send_word(10'h155, 1'b1);
      @(negedge clk);
      checks++;
      if (miso !== 4'h1 || carry_out !== 1'b1) begin
         errors++;
         $display("FAIL mr_n0 got=%h/%b exp=1/1", miso, carry_out);
      end
      spi_pulse();
      checks++;
      if (miso !== 4'h5) begin
         errors++;
         $display("FAIL mr_n1 got=%h exp=5", miso);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (miso !== 4'h0 || carry_out !== 1'b0 ||
          res_ready !== 1'b0 || tx_done !== 1'b0) begin
         errors++;
         $display("FAIL mr_abort got=%h/%b/%b/%b exp=0/0/0/0",
                  miso, carry_out, res_ready, tx_done);
      end
      @(posedge clk);
      #1 rst_n = 1'b0;
      d0 = done_cnt;
      send_word(10'h000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (miso !== 4'h0 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL mr_zero_nib%0d got=%h/%b exp=0/0",
                     i, miso, carry_out);
         end
         spi_pulse();
      end
      checks++;
      if (done_cnt != d0 + 1) begin
         errors++;
         $display("FAIL mr_done got=%0d exp=%0d", done_cnt, d0 + 1);
      end
   endtask

   task automatic test_idle_edges();
      int d0;
      spi_r = 1'b1;
      d0 = done_cnt;
      for (int i = 0; i < 3; i++) begin
         spi_pulse();
         @(negedge clk);
         checks++;
         if (miso !== 4'h0 || res_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_edge%0d got=%h/%b exp=0/1",
                     i, miso, res_ready);
         end
      end
      checks++;
      if (done_cnt != d0) begin
         errors++;
         $display("FAIL idle_done got=%0d exp=%0d", done_cnt, d0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_pause();
      test_back_to_back();
      test_mid_reset();
      test_idle_edges();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               checks, errors);
      $finish;
   end

endmodule
